// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Beat counter width; never narrower than one bit so CHUNK==WIDTH still has a counter.
    function automatic int unsigned beat_cnt_width(input int unsigned nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The sub port exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif

endinterface

// File: rtl/full_adder.sv
// Full adder cell built from two half adders and an OR gate.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (ci),
        .s (s),
        .c (c1)
    );

    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: sums WIDTH-bit operands CHUNK bits per clock through a full-adder ripple.
// Define SERIAL_ADDER_SUB_EN to add a subtract mode (sum = a - b, cout=1 means no borrow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    localparam int unsigned NBEATS = WIDTH / CHUNK;
    localparam int unsigned BW     = beat_cnt_width(NBEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    state_e           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    logic [CHUNK:0]       chain;
    logic [CHUNK-1:0]     chunk_sum;
    logic [WIDTH+CHUNK-1:0] sum_cat;

    assign chain[0] = carry_q;

    for (genvar i = 0; i < CHUNK; i++) begin : g_ripple
        full_adder u_fa (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .ci (chain[i]),
            .s  (chunk_sum[i]),
            .co (chain[i+1])
        );
    end

    // New chunk enters at the MSB; the concatenation avoids a zero-width slice when CHUNK==WIDTH.
    assign sum_cat = {chunk_sum, sum_q};

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
                    if (bus.sub) begin
                        b_d     = ~bus.b;
                        carry_d = 1'b1;
                    end
`endif
                    beat_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                sum_d   = sum_cat[WIDTH+CHUNK-1:CHUNK];
                carry_d = chain[CHUNK];
                beat_d  = beat_q + BW'(1);
                if (beat_q == LAST_BEAT) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            beat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.sum       = sum_q;
    assign bus.cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 with CHUNK=2 and CHUNK=8 instances, scoreboard checked.
module tb_serial_adder;

    localparam int W  = 8;
    localparam int NB = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t exp_q[$];
    exp_t exp8_q[$];

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder_if #(.WIDTH(W)) bus8 ();

    serial_adder #(.WIDTH(W), .CHUNK(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    serial_adder #(.WIDTH(W), .CHUNK(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tc, input logic ts);
        logic [W:0] r;
        if (ts) r = {1'b0, ta} + {1'b0, ~tb} + (W+1)'(1);
        else    r = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        return '{sum: r[W-1:0], cout: r[W]};
    endfunction

    // Accept one operation on the CHUNK=2 instance, then hold the result for 'hold' cycles.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, input int hold, input bit poke);
        exp_t e;
        int   n;
        exp_q.push_back(model(ta, tb, tc, ts));
        @(negedge clk);
        bus.a        = ta;
        bus.b        = tb;
        bus.cin      = tc;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub      = ts;
`endif
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            check("in_ready_busy", 32'(bus.in_ready), 32'd0);
            if (poke && n == 1) begin
                bus.a        = 8'h01;
                bus.b        = 8'h00;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        check("latency", 32'(n), 32'(NB));
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        for (int i = 0; i < hold; i++) begin
            check("hold_sum", 32'(bus.sum), 32'(e.sum));
            check("hold_cout", 32'(bus.cout), 32'(e.cout));
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        check("sum", 32'(bus.sum), 32'(e.sum));
        check("cout", 32'(bus.cout), 32'(e.cout));
        check("out_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("post_valid", 32'(bus.out_valid), 32'd0);
        check("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        exp_t e8;
        int   n;

        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.cin        = 1'b0;
        bus.out_ready  = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.cin       = 1'b0;
        bus8.out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub        = 1'b0;
        bus8.sub       = 1'b0;
`endif

        // Reset state
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'h00);
        check("rst_cout", 32'(bus.cout), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("rel_out_valid", 32'(bus.out_valid), 32'd0);

        // Wrap-around and carry-in cases
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        run_op(8'h5A, 8'h33, 1'b1, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0);

        // Backpressure with an in_valid poke during RUN
        run_op(8'hC3, 8'h7E, 1'b0, 1'b0, 5, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("no_spurious", 32'(bus.out_valid), 32'd0);
        end

        // CHUNK==WIDTH instance: single beat
        exp8_q.push_back(model(8'h5A, 8'h33, 1'b1, 1'b0));
        @(negedge clk);
        bus8.a        = 8'h5A;
        bus8.b        = 8'h33;
        bus8.cin      = 1'b1;
        bus8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        n = 0;
        while (!bus8.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("c8_latency", 32'(n), 32'd1);
        e8 = (exp8_q.size() != 0) ? exp8_q.pop_front() : '0;
        check("c8_sum", 32'(bus8.sum), 32'(e8.sum));
        check("c8_cout", 32'(bus8.cout), 32'(e8.cout));
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus8.out_ready = 1'b0;
        check("c8_post_valid", 32'(bus8.out_valid), 32'd0);

        // Reset at beat 2 of RUN abandons the operation
        @(negedge clk);
        bus.a        = 8'hAA;
        bus.b        = 8'h55;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("midrun_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NB + 1) begin
            @(posedge clk);
            #1;
            check("midrun_no_output", 32'(bus.out_valid), 32'd0);
        end
        run_op(8'h02, 8'h03, 1'b0, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h20, 1'b0, 1'b1, 0, 1'b0);
        run_op(8'h20, 8'h10, 1'b1, 1'b1, 0, 1'b0);
        run_op(8'h20, 8'h10, 1'b1, 1'b0, 0, 1'b0);
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
